drive_arbiter: RTL and testbench

Registered motion arbiter between the ultrasonic range path, the 3-way line tracker and the motor driver. It generalises the fixed 50 cm stop rule into a parametrised controller with:
- stop/resume hysteresis and resume debounce;
- an optional slow zone;
- a line-loss recovery state machine that holds the last steering command before stopping.

Its `mode` output drives the motor block's 2-bit mode input directly.

---
 rtl/drive_arbiter_if.sv | 23 ++
 rtl/drive_arbiter.sv | 138 +++++++++++++
 tb/tb_drive_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/drive_arbiter_if.sv
// Bus between the sensing side (range + line tracker) and the drive arbiter.
// No handshake: every input is sampled on every rising clock and every output is registered, valid each cycle.
interface drive_arbiter_if #(
  parameter int DIST_W = 20
);
  logic [DIST_W-1:0] distance;
  logic [1:0]        tracker_state;
  logic              line_seen;
  logic [1:0]        mode;
  logic              slow;
  logic              blocked;
  logic [2:0]        state;

  modport master (
    output distance, tracker_state, line_seen,
    input  mode, slow, blocked, state
  );

  modport slave (
    input  distance, tracker_state, line_seen,
    output mode, slow, blocked, state
  );
endinterface

// File: rtl/drive_arbiter.sv
// Motion arbiter: obstacle stop/resume hysteresis, optional slow zone, line-loss recovery.
// Define DRIVE_ARB_SLOW_EN to build the SLOW state and the slow-zone compare.
module drive_arbiter #(
  parameter int DIST_W    = 20,
  parameter int STOP_CM   = 50,
  parameter int RESUME_CM = 60,
  parameter int SLOW_CM   = 100,
  parameter int HOLD_CYC  = 1_000_000,
  parameter int LOST_CYC  = 25_000_000
) (
  input logic             clk,
  input logic             rst,
  drive_arbiter_if.slave  bus
);

  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_SLOW    = 3'd1;
  localparam logic [2:0] ST_BLOCKED = 3'd2;
  localparam logic [2:0] ST_RECOVER = 3'd3;
  localparam logic [2:0] ST_LOST    = 3'd4;

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int LOST_W = $clog2(LOST_CYC + 1);

  localparam logic [DIST_W-1:0] STOP_D   = DIST_W'(STOP_CM);
  localparam logic [DIST_W-1:0] RESUME_D = DIST_W'(RESUME_CM);
  localparam logic [DIST_W-1:0] SLOW_D   = DIST_W'(SLOW_CM);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);
  localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_CYC);

  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic [1:0]        last_steer_q, last_steer_d;
  logic [1:0]        mode_q, mode_d;
  logic              slow_q, slow_d;
  logic              blocked_q, blocked_d;

  logic              obstacle;
  logic              clear;
  logic              slow_zone;
  logic [2:0]        track_st;
  logic [HOLD_W-1:0] hold_inc;
  logic [LOST_W-1:0] lost_inc;

  assign obstacle = (bus.distance <= STOP_D);
  assign clear    = (bus.distance >= RESUME_D);

`ifdef DRIVE_ARB_SLOW_EN
  assign slow_zone = (bus.distance <= SLOW_D);
  assign slow_d    = (state_d == ST_SLOW) || (state_d == ST_RECOVER);
`else
  logic slow_cfg_unused;
  assign slow_cfg_unused = ^SLOW_D;
  assign slow_zone       = 1'b0;
  assign slow_d          = 1'b0;
`endif

  assign track_st = slow_zone ? ST_SLOW : ST_RUN;
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
  assign lost_inc = (lost_q == LOST_MAX) ? lost_q : lost_q + LOST_W'(1);

  // Counters stay zero outside their own state, so every entry starts a fresh count.
  always_comb begin
    state_d      = ST_BLOCKED;
    hold_d       = '0;
    lost_d       = '0;
    last_steer_d = last_steer_q;
    case (state_q)
      ST_BLOCKED: begin
        if ((hold_q >= HOLD_MAX) && !obstacle) begin
          state_d = bus.line_seen ? track_st : ST_RECOVER;
        end else begin
          state_d = ST_BLOCKED;
          hold_d  = clear ? hold_inc : '0;
        end
      end
      ST_RUN, ST_SLOW: begin
        if (bus.tracker_state != 2'b00) last_steer_d = bus.tracker_state;
        if (obstacle)           state_d = ST_BLOCKED;
        else if (!bus.line_seen) state_d = ST_RECOVER;
        else                    state_d = track_st;
      end
      ST_RECOVER: begin
        if (obstacle)                state_d = ST_BLOCKED;
        else if (bus.line_seen)      state_d = track_st;
        else if (lost_inc >= LOST_MAX) state_d = ST_LOST;
        else begin
          state_d = ST_RECOVER;
          lost_d  = lost_inc;
        end
      end
      ST_LOST: begin
        if (obstacle)           state_d = ST_BLOCKED;
        else if (bus.line_seen) state_d = track_st;
        else                    state_d = ST_LOST;
      end
      default: state_d = ST_BLOCKED;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_comb begin
    mode_d    = 2'b00;
    blocked_d = (state_d == ST_BLOCKED);
    case (state_d)
      ST_RUN, ST_SLOW: mode_d = bus.tracker_state;
      ST_RECOVER:      mode_d = last_steer_d;
      default:         mode_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLOCKED;
      hold_q       <= '0;
      lost_q       <= '0;
      last_steer_q <= 2'b11;
      mode_q       <= 2'b00;
      slow_q       <= 1'b0;
      blocked_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      lost_q       <= lost_d;
      last_steer_q <= last_steer_d;
      mode_q       <= mode_d;
      slow_q       <= slow_d;
      blocked_q    <= blocked_d;
    end
  end

  assign bus.mode    = mode_q;
  assign bus.slow    = slow_q;
  assign bus.blocked = blocked_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// Bench for drive_arbiter: directed scenarios then random traffic against a rule-level model.
module tb_drive_arbiter;

  localparam int DIST_W = 20;
  localparam int STOP   = 50;
  localparam int RESUME = 60;
  localparam int SLOWCM = 100;
  localparam int HOLD   = 4;
  localparam int LOST   = 8;
`ifdef DRIVE_ARB_SLOW_EN
  localparam bit SLOW_EN = 1'b1;
`else
  localparam bit SLOW_EN = 1'b0;
`endif

  localparam int S_RUN = 0, S_SLOW = 1, S_BLK = 2, S_REC = 3, S_LOST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drive_arbiter_if #(.DIST_W(DIST_W)) arb_if ();

  drive_arbiter #(
    .DIST_W(DIST_W), .STOP_CM(STOP), .RESUME_CM(RESUME), .SLOW_CM(SLOWCM),
    .HOLD_CYC(HOLD), .LOST_CYC(LOST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(arb_if)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];   // {state[2:0], mode[1:0], slow, blocked}

  int         m_state;
  int         m_clear_run;
  int         m_rec_age;
  logic [1:0] m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state     = S_BLK;
    m_clear_run = 0;
    m_rec_age   = 0;
    m_last      = 2'b11;
    exp_q.delete();
  endtask

  // One clock of the arbiter rules, in priority order: obstacle, line loss, tracking.
  task automatic model_step(input int d, input int t, input bit s);
    bit         obst;
    bit         clr;
    int         track;
    int         nxt;
    logic [1:0] md;
    logic [1:0] tr;
    tr    = 2'(t);
    obst  = (d <= STOP);
    clr   = (d >= RESUME);
    track = (SLOW_EN && d <= SLOWCM) ? S_SLOW : S_RUN;
    if ((m_state == S_RUN || m_state == S_SLOW) && tr != 2'b00) m_last = tr;
    if (m_state == S_BLK && !(m_clear_run >= HOLD && !obst)) nxt = S_BLK;
    else if (obst) nxt = S_BLK;
    else if (!s) begin
      if (m_state == S_LOST) nxt = S_LOST;
      else if (m_state == S_REC && m_rec_age + 1 >= LOST) nxt = S_LOST;
      else nxt = S_REC;
    end
    else nxt = track;
    m_clear_run = (nxt == S_BLK && m_state == S_BLK && clr) ? m_clear_run + 1 : 0;
    m_rec_age   = (nxt == S_REC && m_state == S_REC) ? m_rec_age + 1 : 0;
    if (nxt == S_RUN || nxt == S_SLOW) md = tr;
    else if (nxt == S_REC)             md = m_last;
    else                               md = 2'b00;
    m_state = nxt;
    exp_q.push_back({3'(nxt), md, SLOW_EN && (nxt == S_SLOW || nxt == S_REC), nxt == S_BLK});
  endtask

  task automatic check_outputs();
    logic [6:0] e;
    e = exp_q.pop_front();
    check("state",   32'(arb_if.state),   32'(e[6:4]));
    check("mode",    32'(arb_if.mode),    32'(e[3:2]));
    check("slow",    32'(arb_if.slow),    32'(e[1]));
    check("blocked", 32'(arb_if.blocked), 32'(e[0]));
  endtask

  // ---------------- driver ----------------
  task automatic step(input int d, input int t, input bit s);
    arb_if.distance      = DIST_W'(d);
    arb_if.tracker_state = 2'(t);
    arb_if.line_seen     = s;
    @(posedge clk);
    model_step(d, t, s);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic scenario_release();
    for (int i = 0; i < HOLD; i++) begin
      step(200, 3, 1);
      check("rel_blocked", 32'(arb_if.blocked), 32'd1);
      check("rel_slow",    32'(arb_if.slow),    32'd0);
    end
    step(200, 3, 1);
    check("rel_run_state", 32'(arb_if.state), S_RUN);
    check("rel_run_mode",  32'(arb_if.mode),  32'd3);
    check("rel_run_slow",  32'(arb_if.slow),  32'd0);
  endtask

  int dist_cur = 200;
  bit seen_cur = 1'b1;

  function automatic int rand_dist();
    case ($urandom_range(0, 5))
      0:       return $urandom_range(0, 50);
      1:       return $urandom_range(51, 59);
      2:       return $urandom_range(60, 61);
      3:       return $urandom_range(62, 101);
      default: return $urandom_range(102, 1_000_000);
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    arb_if.distance      = DIST_W'(200);
    arb_if.tracker_state = 2'b11;
    arb_if.line_seen     = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state",   32'(arb_if.state),   S_BLK);
    check("rst_mode",    32'(arb_if.mode),    32'd0);
    check("rst_slow",    32'(arb_if.slow),    32'd0);
    check("rst_blocked", 32'(arb_if.blocked), 32'd1);
    rst = 1'b0;

    // release: HOLD clear cycles in BLOCKED, then RUN
    scenario_release();

    // approach: slow zone, then stop at exactly STOP
    step(80, 3, 1);
    check("t2_slow_state", 32'(arb_if.state), SLOW_EN ? S_SLOW : S_RUN);
    check("t2_slow",       32'(arb_if.slow),  32'(SLOW_EN));
    step(50, 3, 1);
    check("t2_stop_state", 32'(arb_if.state), S_BLK);
    check("t2_stop_mode",  32'(arb_if.mode),  32'd0);

    // hysteresis band resets the hold count
    step(70, 3, 1); step(70, 3, 1); step(70, 3, 1); step(55, 3, 1);
    check("t3_band_blocked", 32'(arb_if.blocked), 32'd1);
    for (int i = 0; i < HOLD; i++) begin
      step(70, 3, 1);
      check("t3_hold_blocked", 32'(arb_if.blocked), 32'd1);
    end
    step(200, 3, 1);
    check("t3_exit_state", 32'(arb_if.state), S_RUN);

    // line loss: hold last steering for LOST cycles, then stop
    step(200, 1, 1);
    for (int i = 0; i < LOST; i++) begin
      step(200, 0, 0);
      check("t4_rec_state", 32'(arb_if.state), S_REC);
      check("t4_rec_mode",  32'(arb_if.mode),  32'd1);
    end
    step(200, 0, 0);
    check("t4_lost_state", 32'(arb_if.state), S_LOST);
    check("t4_lost_mode",  32'(arb_if.mode),  32'd0);
    step(200, 3, 1);
    check("t4_back_state", 32'(arb_if.state), S_RUN);

    // line found again mid-recovery; next loss gets the full recovery window
    step(200, 2, 1);
    for (int i = 0; i < 6; i++) step(200, 0, 0);
    step(200, 1, 1);
    check("t5_found_state", 32'(arb_if.state), S_RUN);
    check("t5_found_mode",  32'(arb_if.mode),  32'd1);
    step(200, 1, 1);
    for (int i = 0; i < LOST; i++) begin
      step(200, 0, 0);
      check("t5_rec_state", 32'(arb_if.state), S_REC);
    end
    step(200, 0, 0);
    check("t5_lost_state", 32'(arb_if.state), S_LOST);

    // asynchronous reset between edges while slowing
    step(200, 3, 1);
    step(80, 3, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_state",   32'(arb_if.state),   S_BLK);
    check("t6_rst_mode",    32'(arb_if.mode),    32'd0);
    check("t6_rst_blocked", 32'(arb_if.blocked), 32'd1);
    check("t6_rst_slow",    32'(arb_if.slow),    32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    scenario_release();
    step(80, 3, 1);
    check("t6_zone_slow", 32'(arb_if.slow), 32'(SLOW_EN));

    // random traffic with sticky inputs so holds and recoveries complete
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) dist_cur = rand_dist();
      if ($urandom_range(0, 5) == 0) seen_cur = ~seen_cur;
      step(dist_cur, int'($urandom_range(0, 3)), seen_cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
